// File: rtl/freq_div_pkg.sv
// Shared types and constants for the divided-clock checker.
package freq_div_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAcq,
    StLocked
  } fd_state_e;

  localparam int unsigned ErrCntW = 8;

endpackage

// File: rtl/div_edge_det.sv
// Samples div_in and flags rising/falling transitions of the sampled value.
// FREQ_DIV_CHECKER_SYNC_EN adds a 2-flop synchronizer ahead of the sample register.
module div_edge_det
  import freq_div_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic div_in,
  output logic rise,
  output logic fall
);

  logic s_d, s_q;
  logic p_d, p_q;

`ifdef FREQ_DIV_CHECKER_SYNC_EN
  logic [1:0] sync_d, sync_q;

  always_comb begin
    sync_d = {sync_q[0], div_in};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  always_comb begin
    s_d = sync_q[1];
  end
`else
  always_comb begin
    s_d = div_in;
  end
`endif

  always_comb begin
    p_d = s_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_q <= 1'b0;
      p_q <= 1'b0;
    end else begin
      s_q <= s_d;
      p_q <= p_d;
    end
  end

  assign rise = s_q & ~p_q;
  assign fall = ~s_q & p_q;

endmodule

// File: rtl/freq_div_checker.sv
// Measures half-periods of a divided waveform and locks once LOCK_CNT match N.
// FREQ_DIV_CHECKER_SYNC_EN selects a synchronized div_in (two extra cycles of latency).
module freq_div_checker
  import freq_div_pkg::*;
#(
  parameter int unsigned N        = 7,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               div_in,
  input  logic               clr,
  output logic               rise_p,
  output logic               fall_p,
  output logic [CNT_W-1:0]   half_len,
  output logic               half_vld,
  output logic               locked,
  output logic               err,
  output logic [ErrCntW-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] CntMax   = '1;
  localparam logic [CNT_W-1:0] NLen     = CNT_W'(N);
  localparam int unsigned      StuckLen = 2 * N;
  localparam logic [3:0]       LockVal  = 4'(LOCK_CNT);

  logic rise, fall, edge_det, hit, stuck, log_err;

  fd_state_e          state_d, state_q;
  logic [3:0]         good_d, good_q;
  logic [CNT_W-1:0]   cnt_d, cnt_q;
  logic [CNT_W-1:0]   half_len_d, half_len_q;
  logic               half_vld_d, half_vld_q;
  logic               rise_d, rise_q, fall_d, fall_q;
  logic               locked_d, locked_q, err_d, err_q;
  logic [ErrCntW-1:0] err_cnt_d, err_cnt_q, err_cnt_inc;

  div_edge_det u_edge_det (
    .clk    (clk),
    .rst    (rst),
    .div_in (div_in),
    .rise   (rise),
    .fall   (fall)
  );

  always_comb begin
    edge_det    = rise | fall;
    hit         = (cnt_q == NLen);
    stuck       = !edge_det && (32'(cnt_q) == StuckLen);
    cnt_d       = edge_det ? CNT_W'(1) : ((cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1);
    rise_d      = rise;
    fall_d      = fall;
    // The first half-period after IDLE is partial, so it is never reported.
    half_vld_d  = edge_det && (state_q != StIdle);
    half_len_d  = half_vld_d ? cnt_q : half_len_q;
    err_cnt_inc = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + 1'b1;

    state_d   = state_q;
    good_d    = good_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    log_err   = 1'b0;

    if (clr) begin
      state_d   = StIdle;
      good_d    = '0;
      err_d     = 1'b0;
      err_cnt_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (edge_det) begin
            state_d = StAcq;
            good_d  = '0;
          end
        end
        StAcq: begin
          if (stuck) begin
            state_d = StIdle;
          end else if (edge_det) begin
            if (hit) begin
              good_d = good_q + 4'd1;
              if (good_q + 4'd1 == LockVal) state_d = StLocked;
            end else begin
              good_d = '0;
            end
          end
        end
        StLocked: begin
          if (stuck) begin
            state_d = StIdle;
            log_err = 1'b1;
          end else if (edge_det && !hit) begin
            state_d = StAcq;
            good_d  = '0;
            log_err = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
      if (log_err) begin
        err_d     = 1'b1;
        err_cnt_d = err_cnt_inc;
      end
    end

    locked_d = (state_d == StLocked);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      good_q     <= '0;
      cnt_q      <= '0;
      half_len_q <= '0;
      half_vld_q <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      good_q     <= good_d;
      cnt_q      <= cnt_d;
      half_len_q <= half_len_d;
      half_vld_q <= half_vld_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign rise_p   = rise_q;
  assign fall_p   = fall_q;
  assign half_len = half_len_q;
  assign half_vld = half_vld_q;
  assign locked   = locked_q;
  assign err      = err_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_freq_div_checker.sv
// Scoreboard bench for freq_div_checker: a reference model predicts every output cycle.
module tb_freq_div_checker;

  localparam int unsigned N       = 7;
  localparam int unsigned CntW    = 8;
  localparam int unsigned LockCnt = 4;
  localparam int          CntMaxI = (1 << CntW) - 1;
`ifdef FREQ_DIV_CHECKER_SYNC_EN
  localparam int Lat       = 4;
  localparam int SyncDepth = 2;
`else
  localparam int Lat       = 2;
  localparam int SyncDepth = 0;
`endif

  logic            clk    = 1'b0;
  logic            rst    = 1'b0;
  logic            div_in = 1'b0;
  logic            clr    = 1'b0;
  logic            rise_p, fall_p, half_vld, locked, err;
  logic [CntW-1:0] half_len;
  logic [7:0]      err_cnt;

  freq_div_checker #(
    .N        (N),
    .CNT_W    (CntW),
    .LOCK_CNT (LockCnt)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .div_in   (div_in),
    .clr      (clr),
    .rise_p   (rise_p),
    .fall_p   (fall_p),
    .half_len (half_len),
    .half_vld (half_vld),
    .locked   (locked),
    .err      (err),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  function automatic void chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  typedef struct {
    int unsigned at;
    bit          rise;
    bit          fall;
    bit          vld;
    int          len;
    bit          locked;
    bit          err;
    int          errc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  // Reference model: half-period = cycles between successive sampled transitions.
  int m_state;  // 0 idle, 1 acquiring, 2 locked
  int m_good, m_errc, m_len, m_c, m_last;
  bit m_err, m_x1, m_x0;
  bit pipe[$];

  task automatic model_reset();
    m_state = 0; m_good = 0; m_err = 0; m_errc = 0; m_len = 0;
    m_c = 0; m_last = 0; m_x1 = 0; m_x0 = 0;
    pipe.delete();
    for (int i = 0; i < SyncDepth; i++) pipe.push_back(1'b0);
  endtask

  task automatic model_step(input bit x_new, input bit clr_new);
    exp_t e;
    bit   edge_now, hit, stuck, log_err, xin;
    int   cnt;
    edge_now = (m_x1 != m_x0);
    cnt      = m_c - m_last;
    if (cnt > CntMaxI) cnt = CntMaxI;
    hit      = (cnt == N);
    stuck    = !edge_now && (cnt == 2 * N);
    e.rise   = edge_now && m_x1;
    e.fall   = edge_now && !m_x1;
    e.vld    = edge_now && (m_state != 0);
    if (e.vld) m_len = cnt;
    log_err = 0;
    if (clr_new) begin
      m_state = 0; m_good = 0; m_err = 0; m_errc = 0;
    end else begin
      case (m_state)
        0: if (edge_now) begin m_state = 1; m_good = 0; end
        1: begin
          if (stuck) m_state = 0;
          else if (edge_now) begin
            m_good = hit ? m_good + 1 : 0;
            if (m_good == LockCnt) m_state = 2;
          end
        end
        default: begin
          if (stuck) begin m_state = 0; log_err = 1; end
          else if (edge_now && !hit) begin m_state = 1; m_good = 0; log_err = 1; end
        end
      endcase
      if (log_err) begin
        m_err = 1;
        if (m_errc < 255) m_errc++;
      end
    end
    e.len    = m_len;
    e.locked = (m_state == 2);
    e.err    = m_err;
    e.errc   = m_errc;
    e.at     = cyc + 1;
    exp_q.push_back(e);
    if (edge_now) m_last = m_c;
    pipe.push_back(x_new);
    xin  = pipe.pop_front();
    m_x0 = m_x1;
    m_x1 = xin;
    m_c++;
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
      mon_e = exp_q.pop_front();
      chk("rise_p",   int'(rise_p),   int'(mon_e.rise));
      chk("fall_p",   int'(fall_p),   int'(mon_e.fall));
      chk("half_vld", int'(half_vld), int'(mon_e.vld));
      chk("half_len", int'(half_len), mon_e.len);
      chk("locked",   int'(locked),   int'(mon_e.locked));
      chk("err",      int'(err),      int'(mon_e.err));
      chk("err_cnt",  int'(err_cnt),  mon_e.errc);
    end
  end

  bit lvl;

  task automatic tick(input bit x, input bit c);
    model_step(x, c);
    div_in = x;
    clr    = c;
    @(posedge clk);
    #1;
  endtask

  task automatic half(input int len, input int clr_at);
    lvl = ~lvl;
    for (int i = 0; i < len; i++) tick(lvl, i == clr_at);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    exp_q.delete();
    div_in = 1'b0;
    clr    = 1'b0;
    lvl    = 1'b0;
    #1;
    chk("rst_rise_p",   int'(rise_p),   0);
    chk("rst_fall_p",   int'(fall_p),   0);
    chk("rst_half_vld", int'(half_vld), 0);
    chk("rst_half_len", int'(half_len), 0);
    chk("rst_locked",   int'(locked),   0);
    chk("rst_err",      int'(err),      0);
    chk("rst_err_cnt",  int'(err_cnt),  0);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    do_reset();

    // Latency from a div_in change to rise_p.
    repeat (3) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    lvl = 1'b1;
    n = 1;
    while (!rise_p && n < 12) begin
      tick(1'b1, 1'b0);
      n++;
    end
    chk("rise_latency", n, Lat);

    // Clean divider output locks; one stretched half breaks and relocks.
    do_reset();
    repeat (6) half(N, -1);
    chk("lock_locked", int'(locked), 1);
    chk("lock_err", int'(err), 0);
    half(9, -1);
    repeat (6) half(N, -1);
    chk("relock_locked", int'(locked), 1);
    chk("relock_err", int'(err), 1);
    chk("relock_err_cnt", int'(err_cnt), 1);

    // Stuck input while locked.
    do_reset();
    repeat (6) half(N, -1);
    repeat (20) tick(lvl, 1'b0);
    chk("stuck_locked", int'(locked), 0);
    chk("stuck_err", int'(err), 1);
    chk("stuck_err_cnt", int'(err_cnt), 1);

    // clr lands in the same cycle as a mismatching edge.
    do_reset();
    repeat (6) half(N, -1);
    half(9, -1);
    half(N, Lat - 1);
    chk("clr_err", int'(err), 0);
    chk("clr_err_cnt", int'(err_cnt), 0);
    chk("clr_locked", int'(locked), 0);

    // Randomized half-periods with occasional clr and stuck holds.
    do_reset();
    for (int i = 0; i < 250; i++) begin
      int len, ca;
      len = ($urandom_range(0, 9) < 7) ? N : $urandom_range(1, 16);
      ca  = ($urandom_range(0, 19) == 0) ? $urandom_range(0, len - 1) : -1;
      half(len, ca);
    end

    // Error counter saturation.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      repeat (5) half(N, -1);
      half(9, -1);
    end
    half(N, -1);
    chk("sat_err_cnt", int'(err_cnt), 255);

    // Asynchronous reset while locked.
    repeat (5) half(N, -1);
    chk("pre_rst_locked", int'(locked), 1);
    do_reset();
    repeat (5) tick(lvl, 1'b0);
    chk("post_rst_locked", int'(locked), 0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
